// File: rtl/spi_cipo_transmitter.sv
// SPI mode-0 peripheral transmitter: oversamples SCLK/CS in the clk domain and
// shifts bytes MSB-first on CIPO from a one-entry holding register.
module spi_cipo_transmitter #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       SCLK,
    input  logic       spi_cs_n,
    output logic       CIPO,
    output logic       cipo_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       byte_sent,
    output logic       underrun,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_reg;
    logic [SYNC_STAGES-1:0] cs_sync_reg;
    logic                   sclk_hist_reg;
    logic                   cs_hist_reg;

    state_t      state_reg;
    logic [7:0]  sreg_reg;
    logic [2:0]  bit_cnt_reg;
    logic        reload_reg;
    logic        cipo_oe_reg;
    logic        busy_reg;
    logic        byte_sent_reg;
    logic        underrun_reg;
    logic [7:0]  hold_reg;
    logic        full_reg;

    logic sclk_s, cs_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic do_load, load_from_hold, accept;
    logic [7:0] load_byte;

    // CS synchronizer resets to the deasserted level so reset release is not seen as cs_fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_reg <= '0;
            cs_sync_reg   <= '1;
            sclk_hist_reg <= 1'b0;
            cs_hist_reg   <= 1'b1;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], SCLK};
            cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], spi_cs_n};
            sclk_hist_reg <= sclk_sync_reg[SYNC_STAGES-1];
            cs_hist_reg   <= cs_sync_reg[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
    assign cs_s      = cs_sync_reg[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist_reg;
    assign sclk_fall = ~sclk_s & sclk_hist_reg;
    assign cs_fall   = ~cs_s & cs_hist_reg;
    assign cs_rise   = cs_s & ~cs_hist_reg;

    // A load happens in LOAD, or on the first falling edge after a completed byte.
    assign do_load        = (state_reg == LOAD) ||
                            ((state_reg == SHIFT) && !cs_s && sclk_fall && reload_reg);
    assign load_from_hold = do_load && full_reg;
    assign load_byte      = full_reg ? hold_reg : IDLE_BYTE;
    assign accept         = tx_valid && !full_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg <= 8'h00;
            full_reg <= 1'b0;
        end else if (load_from_hold) begin
            full_reg <= 1'b0;
        end else if (accept) begin
            hold_reg <= tx_data;
            full_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            sreg_reg      <= 8'h00;
            bit_cnt_reg   <= 3'd0;
            reload_reg    <= 1'b0;
            cipo_oe_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            byte_sent_reg <= 1'b0;
            underrun_reg  <= 1'b0;
        end else begin
            byte_sent_reg <= 1'b0;
            underrun_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    bit_cnt_reg <= 3'd0;
                    reload_reg  <= 1'b0;
                    if (cs_fall) begin
                        state_reg   <= LOAD;
                        cipo_oe_reg <= 1'b1;
                        busy_reg    <= 1'b1;
                    end
                end
                LOAD: begin
                    sreg_reg     <= load_byte;
                    underrun_reg <= !full_reg;
                    bit_cnt_reg  <= 3'd0;
                    reload_reg   <= 1'b0;
                    state_reg    <= SHIFT;
                end
                SHIFT: begin
                    // Level check also catches a CS release that landed during LOAD.
                    if (cs_s) begin
                        state_reg   <= IDLE;
                        sreg_reg    <= 8'h00;
                        bit_cnt_reg <= 3'd0;
                        reload_reg  <= 1'b0;
                        cipo_oe_reg <= 1'b0;
                        busy_reg    <= 1'b0;
                    end else if (sclk_rise) begin
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            byte_sent_reg <= 1'b1;
                            reload_reg    <= 1'b1;
                        end
                    end else if (sclk_fall) begin
                        if (reload_reg) begin
                            sreg_reg     <= load_byte;
                            underrun_reg <= !full_reg;
                            reload_reg   <= 1'b0;
                        end else begin
                            sreg_reg <= {sreg_reg[6:0], 1'b0};
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign CIPO      = cipo_oe_reg & sreg_reg[7];
    assign cipo_oe   = cipo_oe_reg;
    assign busy      = busy_reg;
    assign byte_sent = byte_sent_reg;
    assign underrun  = underrun_reg;
    assign tx_ready  = !full_reg;

endmodule

// File: tb/tb_spi_cipo_transmitter.sv
// Bench for spi_cipo_transmitter: a host model shifts bytes in on SCLK rise and
// compares them against a queue of expected bytes; a second instance uses IDLE_BYTE=00.
module tb_spi_cipo_transmitter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       SCLK = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       CIPO, cipo_oe, tx_ready, byte_sent, underrun, busy;
    logic       CIPO0, cipo_oe0, tx_ready0, byte_sent0, underrun0, busy0;

    int checks = 0;
    int errors = 0;
    int bs_cnt = 0;
    int ur_cnt = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    spi_cipo_transmitter #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
        .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .spi_cs_n(spi_cs_n),
        .CIPO(CIPO), .cipo_oe(cipo_oe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .byte_sent(byte_sent), .underrun(underrun), .busy(busy)
    );

    spi_cipo_transmitter #(.SYNC_STAGES(2), .IDLE_BYTE(8'h00)) dut0 (
        .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .spi_cs_n(spi_cs_n),
        .CIPO(CIPO0), .cipo_oe(cipo_oe0), .tx_data(8'h00), .tx_valid(1'b0),
        .tx_ready(tx_ready0), .byte_sent(byte_sent0), .underrun(underrun0), .busy(busy0)
    );

    always @(negedge clk) begin
        if (byte_sent) bs_cnt <= bs_cnt + 1;
        if (underrun)  ur_cnt <= ur_cnt + 1;
    end

    task automatic tx_send(input logic [7:0] b, input bit push);
        int n = 0;
        while (!tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!tx_ready) begin
            errors++;
            $display("FAIL tx_send_timeout byte=%02h tx_ready=%0b required=1", b, tx_ready);
        end else begin
            if (push) exp_q.push_back(b);
            tx_data  = b;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
            $display("tx offered %02h", b);
        end
    endtask

    // CS release coincides with the final SCLK fall so no extra byte is fetched.
    task automatic spi_xfer(input int nbytes);
        logic [7:0] rx, rx0, e;
        spi_cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int b = 0; b < nbytes; b++) begin
            for (int i = 0; i < 8; i++) begin
                SCLK = 1'b1;
                rx  = {rx[6:0], CIPO};
                rx0 = {rx0[6:0], CIPO0};
                repeat (8) @(negedge clk);
                SCLK = 1'b0;
                if (b == nbytes - 1 && i == 7) spi_cs_n = 1'b1;
                repeat (8) @(negedge clk);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rx_unexpected got=%02h required=none", rx);
            end else begin
                e = exp_q.pop_front();
                if (rx !== e) begin
                    errors++;
                    $display("FAIL rx_byte got=%02h required=%02h", rx, e);
                end else begin
                    $display("rx byte %02h ok", rx);
                end
            end
            checks++;
            if (rx0 !== 8'h00) begin
                errors++;
                $display("FAIL rx_idle00 got=%02h required=00", rx0);
            end
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic check_counts(input string name, input int bs0, input int ur0,
                                input int bs_exp, input int ur_exp);
        checks++;
        if (bs_cnt - bs0 !== bs_exp) begin
            errors++;
            $display("FAIL %s_byte_sent got=%0d required=%0d", name, bs_cnt - bs0, bs_exp);
        end
        checks++;
        if (ur_cnt - ur0 !== ur_exp) begin
            errors++;
            $display("FAIL %s_underrun got=%0d required=%0d", name, ur_cnt - ur0, ur_exp);
        end
        $display("%s pulses byte_sent=%0d underrun=%0d", name, bs_cnt - bs0, ur_cnt - ur0);
    endtask

    task automatic test_reset();
        logic [5:0] o;
        repeat (4) @(negedge clk);
        o = {CIPO, cipo_oe, tx_ready, byte_sent, underrun, busy};
        checks++;
        if (o !== 6'b001000) begin
            errors++;
            $display("FAIL reset_values got=%06b required=001000", o);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        tx_send(8'h80, 1'b0);
        spi_cs_n = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if ({CIPO, busy, cipo_oe} !== 3'b111) begin
            errors++;
            $display("FAIL first_msb got=%03b required=111", {CIPO, busy, cipo_oe});
        end
        tx_send(8'h77, 1'b0);
        checks++;
        if (tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL holding_full got=%0b required=0", tx_ready);
        end
        SCLK = 1'b1;
        repeat (8) @(negedge clk);
        SCLK = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        o = {CIPO, cipo_oe, tx_ready, byte_sent, underrun, busy};
        checks++;
        if (o !== 6'b001000) begin
            errors++;
            $display("FAIL async_reset got=%06b required=001000", o);
        end
        spi_cs_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if ({tx_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL post_reset got=%02b required=10", {tx_ready, busy});
        end
        $display("reset test done");
    endtask

    task automatic test_single();
        int bs0 = bs_cnt, ur0 = ur_cnt;
        tx_send(8'hA5, 1'b1);
        spi_xfer(1);
        check_counts("single", bs0, ur0, 1, 0);
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_tx_ready got=%0b required=1", tx_ready);
        end
    endtask

    task automatic test_back_to_back();
        int bs0 = bs_cnt, ur0 = ur_cnt;
        tx_send(8'h3C, 1'b1);
        fork
            spi_xfer(2);
            tx_send(8'hC3, 1'b1);
        join
        check_counts("b2b", bs0, ur0, 2, 0);
    endtask

    task automatic test_underrun();
        int bs0 = bs_cnt, ur0 = ur_cnt;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        spi_xfer(2);
        check_counts("underrun", bs0, ur0, 2, 2);
    endtask

    task automatic test_abort();
        int bs0 = bs_cnt, ur0 = ur_cnt;
        tx_send(8'hF0, 1'b0);
        spi_cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            SCLK = 1'b1;
            repeat (8) @(negedge clk);
            SCLK = 1'b0;
            repeat (8) @(negedge clk);
        end
        tx_send(8'h0F, 1'b1);
        repeat (4) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
        check_counts("abort", bs0, ur0, 0, 0);
        bs0 = bs_cnt;
        ur0 = ur_cnt;
        spi_xfer(1);
        check_counts("after_abort", bs0, ur0, 1, 0);
    endtask

    task automatic test_simultaneous();
        int bs0 = bs_cnt, ur0 = ur_cnt;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h5A);
        fork
            spi_xfer(2);
            begin
                // Third negedge after CS falls sits in the LOAD cycle.
                repeat (3) @(negedge clk);
                tx_data  = 8'h5A;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
                $display("tx offered 5A during LOAD");
            end
        join
        check_counts("simultaneous", bs0, ur0, 2, 1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_underrun();
        test_abort();
        test_simultaneous();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
